// File: rtl/vscale_hasti_mem_bist_if.sv
// HASTI bus constants and the master/slave bus bundle
// used by the memory BIST engine.
package vscale_hasti_pkg;
  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;
  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int HASTI_RESP_WIDTH  = 1;

  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'd0;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'd2;
  localparam logic [HASTI_SIZE_WIDTH-1:0]  HASTI_SIZE_WORD    = 3'd2;
  localparam logic [HASTI_BURST_WIDTH-1:0] HASTI_BURST_SINGLE = 3'd0;
  localparam logic [HASTI_PROT_WIDTH-1:0]  HASTI_NO_PROT      = 4'b0011;
endpackage

interface vscale_hasti_mem_bist_if;
  import vscale_hasti_pkg::*;

  logic [HASTI_ADDR_WIDTH-1:0]  haddr;
  logic                         hwrite;
  logic [HASTI_SIZE_WIDTH-1:0]  hsize;
  logic [HASTI_BURST_WIDTH-1:0] hburst;
  logic                         hmastlock;
  logic [HASTI_PROT_WIDTH-1:0]  hprot;
  logic [HASTI_TRANS_WIDTH-1:0] htrans;
  logic [HASTI_BUS_WIDTH-1:0]   hwdata;
  logic [HASTI_BUS_WIDTH-1:0]   hrdata;
  logic                         hready;
  logic [HASTI_RESP_WIDTH-1:0]  hresp;

  modport master (
    output haddr, hwrite, hsize, hburst,
    output hmastlock, hprot, htrans, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, hwrite, hsize, hburst,
    input  hmastlock, hprot, htrans, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/vscale_hasti_mem_bist.sv
// HASTI master that writes a seeded ramp over a word range,
// reads it back and counts mismatches and error responses.
module vscale_hasti_mem_bist
  import vscale_hasti_pkg::*;
#(
  parameter int NWORDS_WIDTH = 16,
  parameter int ERR_WIDTH    = 16
) (
  input  logic                        hclk,
  input  logic                        hresetn,
  input  logic                        start,
  input  logic [HASTI_ADDR_WIDTH-1:0] base_addr,
  input  logic [NWORDS_WIDTH-1:0]     nwords,
  input  logic [HASTI_BUS_WIDTH-1:0]  seed,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [ERR_WIDTH-1:0]        err_count,
  output logic [HASTI_ADDR_WIDTH-1:0] first_err_addr,
  vscale_hasti_mem_bist_if.master     bus
);

  localparam int AW = HASTI_ADDR_WIDTH;
  localparam int BW = HASTI_BUS_WIDTH;
  localparam int NW = NWORDS_WIDTH;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR     = 3'd1;
  localparam logic [2:0] S_TURN   = 3'd2;
  localparam logic [2:0] S_RD     = 3'd3;
  localparam logic [2:0] S_RDLAST = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]    state;
  logic [NW-1:0] idx;
  logic [NW-1:0] last;
  logic [AW-1:0] base_q;
  logic [BW-1:0] seed_q;

  logic          dp_act;
  logic          dp_wr;
  logic [BW-1:0] dp_pat;
  logic [AW-1:0] dp_addr;

  logic          act;
  logic [AW-1:0] addr_cur;
  logic          rd_bad;
  logic          dp_err;

  assign act      = (state == S_WR) || (state == S_RD);
  assign addr_cur = base_q + (AW'(idx) << 2);

  assign bus.haddr     = addr_cur;
  assign bus.htrans    = act ? HASTI_TRANS_NONSEQ
                             : HASTI_TRANS_IDLE;
  assign bus.hwrite    = (state == S_WR);
  assign bus.hwdata    = dp_pat;
  assign bus.hsize     = HASTI_SIZE_WORD;
  assign bus.hburst    = HASTI_BURST_SINGLE;
  assign bus.hmastlock = 1'b0;
  assign bus.hprot     = HASTI_NO_PROT;

  assign busy = (state == S_WR) || (state == S_TURN)
             || (state == S_RD) || (state == S_RDLAST);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == '0);

  assign rd_bad = !dp_wr && (bus.hrdata != dp_pat);
  assign dp_err = dp_act && ((bus.hresp != '0) || rd_bad);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state          <= S_IDLE;
      idx            <= '0;
      last           <= '0;
      base_q         <= '0;
      seed_q         <= '0;
      dp_act         <= 1'b0;
      dp_wr          <= 1'b0;
      dp_pat         <= '0;
      dp_addr        <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (state == S_IDLE || state == S_DONE) begin
      if (start) begin
        base_q         <= base_addr & ~AW'(3);
        seed_q         <= seed;
        last           <= nwords - NW'(1);
        idx            <= '0;
        err_count      <= '0;
        first_err_addr <= '0;
        // empty range still spends one cycle before DONE
        state <= (nwords == '0) ? S_RDLAST : S_WR;
      end
    end else if (bus.hready) begin
      if (dp_err && err_count == '0)
        first_err_addr <= dp_addr;
      if (dp_err && err_count != '1)
        err_count <= err_count + ERR_WIDTH'(1);
      dp_act <= act;
      dp_wr  <= (state == S_WR);
      if (act) begin
        dp_pat  <= seed_q + BW'(idx);
        dp_addr <= addr_cur;
      end
      unique case (1'b1)
        (state == S_WR): begin
          if (idx == last) begin
            idx   <= '0;
            state <= S_TURN;
          end else begin
            idx <= idx + NW'(1);
          end
        end
        (state == S_TURN): state <= S_RD;
        (state == S_RD): begin
          if (idx == last) begin
            idx   <= '0;
            state <= S_RDLAST;
          end else begin
            idx <= idx + NW'(1);
          end
        end
        (state == S_RDLAST): state <= S_DONE;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/vscale_hasti_mem_bist.md
# vscale_hasti_mem_bist

HASTI bus master that fills a word range of the dual-port test SRAM with a seeded pattern, reads it back, and reports mismatches. It sits directly upstream of the SRAM data port (p0) in the test harness. It exercises the SRAM's pipelined address/data phases and byte-mask path at full-word size, with no CPU involvement.

## Interface
- `NWORDS_WIDTH`, 16: width of the word-count input. The range ceiling is 2^NWORDS_WIDTH-1 words.
- `ERR_WIDTH`, 16: width of the saturating error counter.
- `hclk` input 1: the single clock.
- `hresetn` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle start pulse, sampled only in IDLE.
- `base_addr` input `HASTI_ADDR_WIDTH`: byte address of word 0; bits [1:0] are ignored and forced to 0.
- `nwords` input NWORDS_WIDTH: number of words to test, sampled with `start`.
- `seed` input `HASTI_BUS_WIDTH`: pattern seed, sampled with `start`.
- `busy` output 1: high from the cycle after an accepted `start` until the cycle before `done` rises.
- `done` output 1: high in DONE; held until the next accepted `start`.
- `pass` output 1: valid while `done`=1; equals (err_count==0).
- `err_count` output ERR_WIDTH: number of mismatches plus error responses; saturates at all-ones.
- `first_err_addr` output `HASTI_ADDR_WIDTH`: byte address of the first failing read; 0 if there is none.
- `haddr`, `hwrite`, `hsize`, `hburst`, `hmastlock`, `hprot`, `htrans`, `hwdata` outputs: the HASTI master request, at the widths given in the HASTI constants.
- `hrdata`, `hready`, `hresp` inputs: the HASTI slave response.

## Operation
- Fixed outputs:
  - hsize=2 (word)
  - hburst=SINGLE (0)
  - hmastlock=0
  - hprot=4'b0011
  - Only htrans values IDLE (0) and NONSEQ (2) are used.
- Pattern: P(i) = seed + i, mod 2^32.
- Address: A(i) = base + 4*i, mod 2^32.
- States:
  - IDLE: htrans=IDLE. On `start`: latch the inputs and clear err_count, first_err_addr and done. If nwords=0, go to DONE; otherwise go to WR.
  - WR: issue NONSEQ write, address phase for word i. In the following data phase, hwdata=P(i). After the last address phase, go to TURN.
  - TURN: one idle cycle; htrans=IDLE, and the final write data phase completes here. Then go to RD.
  - RD: issue NONSEQ read, address phase for word i. In the following data phase, compare hrdata with P(i). After the last address phase, go to RDLAST.
  - RDLAST: htrans=IDLE; final read data phase. Then go to DONE.
  - DONE: htrans=IDLE; done=1. On `start`, behave as in IDLE.
- Pipelining: the address phase of word i+1 overlaps the data phase of word i.
- Stall: while hready=0, hold haddr, htrans, hwrite and hwdata, and do not compare or advance. A phase completes only on a cycle with hready=1.
- Error: in a read data phase with hready=1, increment err_count if hrdata≠P(i) or hresp=1. Count an hresp=1 during a write data phase as well.
  - first_err_addr captures A(i) on the first error only.
- `start` while busy is ignored.
- Reset mid-run: the state machine goes to IDLE immediately and htrans=IDLE. The SRAM contents left behind are undefined.

## Timing
- Reset values:
  - busy=0, done=0, pass=0
  - err_count=0, first_err_addr=0
  - htrans=IDLE, hwrite=0, haddr=0, hwdata=0
- With `start` in cycle 0 and hready held at 1:
  - Write address phases occupy cycles 1..N.
  - TURN is cycle N+1.
  - Read address phases occupy cycles N+2..2N+1.
  - RDLAST is cycle 2N+2.
  - done=1 from cycle 2N+3.
- For nwords=0, done=1 in cycle 2.
- Each cycle of hready=0 adds exactly one cycle to the total.
- err_count and pass reflect the final comparison in the same cycle that done rises.

## Test plan
- **Clean run**: base=0x100, nwords=4, seed=0xA5A50000, hready=1 → SRAM words 0x40..0x43 hold 0xA5A50000..0xA5A50003; done in cycle 11; pass=1; err_count=0.
- **Injected fault**: same run, but the bench forces word 0x42 to 0 after TURN → err_count=1; first_err_addr=0x108; pass=0.
- **Wait states**: hready low for 3 cycles in the middle of WR and 2 cycles in the middle of RD → no duplicated or skipped beats; done in cycle 16; pass=1.
- **Zero and wrap**:
  - nwords=0 → done in cycle 2, pass=1, no NONSEQ seen.
  - seed=0xFFFFFFFE, nwords=3 → patterns 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- **Saturation and error response**:
  - With ERR_WIDTH=2 and 5 forced mismatches → err_count=3.
  - hresp=1 on one read → counted as an error.
- **Reset and start handling**: assert hresetn low in cycle 3 of a run → htrans=IDLE and all outputs at reset values immediately; a `start` asserted during busy is ignored.
